// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared sizing, state encoding and vector helper.
package interrupt_controller_pkg;
    localparam int N_IRQ = 4;
    localparam int VEC_WIDTH = 5;
    localparam int SEL_W = 2;
    localparam logic [VEC_WIDTH-1:0] VEC_BASE = 5'd24;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
    // Two ROM words per vector table entry; wraps modulo 2^VEC_WIDTH.
    function automatic logic [VEC_WIDTH-1:0] vec_of(input logic [SEL_W-1:0] sel);
        return VEC_BASE + VEC_WIDTH'({sel, 1'b0});
    endfunction
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: request/ack/mask bus between core side and controller.
interface interrupt_controller_if;
    import interrupt_controller_pkg::*;
    logic [N_IRQ-1:0] irq_in;
    logic mask_we;
    logic [N_IRQ-1:0] mask_in;
    logic irq_ack;
    logic iret;
    logic irq_out;
    logic [VEC_WIDTH-1:0] vector;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] pending;
    logic busy;
    modport master (
        output irq_in, mask_we, mask_in, irq_ack, iret,
        input irq_out, vector, active, pending, busy
    );
    modport slave (
        input irq_in, mask_we, mask_in, irq_ack, iret,
        output irq_out, vector, active, pending, busy
    );
endinterface

// File: rtl/interrupt_controller_prio_enc4.sv
// prio_enc4: lowest-set-bit index of a 4-bit request vector plus valid flag.
module prio_enc4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);
    always_comb begin
        idx = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
        valid = |req;
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, maskable, fixed-priority, non-nesting interrupt controller.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input logic clk,
    input logic rst_n,
    interrupt_controller_if.slave bus
);
    state_t state_q, state_d;
    logic [N_IRQ-1:0] prev_q, pending_q, mask_q, active_q, rise, clr;
    logic armed_q, win_valid, ack, ret;
    logic [SEL_W-1:0] sel_q, win;
    logic [VEC_WIDTH-1:0] vector_q;

    prio_enc4 u_prio (.req(pending_q & mask_q), .idx(win), .valid(win_valid));

    // armed_q suppresses edges on the first sample after reset so a line
    // already high at release does not fire.
    always_comb begin
        rise = bus.irq_in & ~prev_q & {N_IRQ{armed_q}};
        ack = (state_q == REQ) && bus.irq_ack;
        ret = (state_q == SERVICE) && bus.iret;
        clr = ack ? N_IRQ'(1) << sel_q : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_valid ? REQ : IDLE;
            REQ:     state_d = bus.irq_ack ? SERVICE : REQ;
            SERVICE: state_d = bus.iret ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            prev_q <= '0;
            pending_q <= '0;
            mask_q <= '0;
            active_q <= '0;
            sel_q <= '0;
            vector_q <= '0;
        end else begin
            armed_q <= 1'b1;
            prev_q <= bus.irq_in;
            pending_q <= (pending_q & ~clr) | rise;
            mask_q <= bus.mask_we ? bus.mask_in : mask_q;
            active_q <= ack ? clr : ret ? '0 : active_q;
            if (state_q == IDLE && win_valid) begin
                sel_q <= win;
                vector_q <= vec_of(win);
            end
        end
    end

    assign bus.irq_out = state_q == REQ;
    assign bus.busy = (state_q == REQ) || (state_q == SERVICE);
    assign bus.vector = vector_q;
    assign bus.active = active_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus with immediate-assertion checks.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    interrupt_controller_if bus();
    interrupt_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_irq_out"}, 32'(bus.irq_out), 32'd0);
        chk({tag, "_vector"}, 32'(bus.vector), 32'd0);
        chk({tag, "_active"}, 32'(bus.active), 32'd0);
        chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.irq_in = '0;
        bus.mask_we = 1'b0;
        bus.mask_in = '0;
        bus.irq_ack = 1'b0;
        bus.iret = 1'b0;
        #23;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        bus.mask_we = 1'b1; bus.mask_in = 4'b1111;
        step();
        bus.mask_we = 1'b0;
        // single line 2
        bus.irq_in = 4'b0100;
        step();
        bus.irq_in = 4'b0000;
        chk("l2_pending", 32'(bus.pending), 32'h4);
        chk("l2_no_irq_yet", 32'(bus.irq_out), 32'd0);
        step();
        chk("l2_irq_out", 32'(bus.irq_out), 32'd1);
        chk("l2_vector", 32'(bus.vector), 32'd28);
        chk("l2_busy_req", 32'(bus.busy), 32'd1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("l2_active", 32'(bus.active), 32'h4);
        chk("l2_pending_clr", 32'(bus.pending), 32'h0);
        chk("l2_irq_out_svc", 32'(bus.irq_out), 32'd0);
        chk("l2_busy_svc", 32'(bus.busy), 32'd1);
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        chk("l2_busy_done", 32'(bus.busy), 32'd0);
        chk("l2_active_done", 32'(bus.active), 32'h0);
        chk("l2_vector_held", 32'(bus.vector), 32'd28);
        // simultaneous lines 1 and 3
        bus.irq_in = 4'b1010;
        step();
        bus.irq_in = 4'b0000;
        chk("l13_pending", 32'(bus.pending), 32'ha);
        step();
        chk("l13_vector1", 32'(bus.vector), 32'd26);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("l13_active1", 32'(bus.active), 32'h2);
        chk("l13_pending3", 32'(bus.pending), 32'h8);
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        chk("l13_idle_gap", 32'(bus.irq_out), 32'd0);
        step();
        chk("l13_irq_out3", 32'(bus.irq_out), 32'd1);
        chk("l13_vector3", 32'(bus.vector), 32'd30);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        chk("l13_busy_done", 32'(bus.busy), 32'd0);
        // masked line 0 is retained
        bus.mask_we = 1'b1; bus.mask_in = 4'b1110;
        step();
        bus.mask_we = 1'b0;
        bus.irq_in = 4'b0001;
        step();
        bus.irq_in = 4'b0000;
        chk("mask_pending", 32'(bus.pending), 32'h1);
        step();
        chk("mask_no_irq_a", 32'(bus.irq_out), 32'd0);
        step();
        chk("mask_no_irq_b", 32'(bus.irq_out), 32'd0);
        bus.mask_we = 1'b1; bus.mask_in = 4'b1111;
        step();
        bus.mask_we = 1'b0;
        chk("mask_write_edge", 32'(bus.irq_out), 32'd0);
        step();
        chk("unmask_irq_out", 32'(bus.irq_out), 32'd1);
        chk("unmask_vector", 32'(bus.vector), 32'd24);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("unmask_active", 32'(bus.active), 32'h1);
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        // higher-priority arrival while committed to line 2
        bus.irq_in = 4'b0100;
        step();
        bus.irq_in = 4'b0000;
        step();
        bus.irq_in = 4'b0001;
        step();
        bus.irq_in = 4'b0000;
        chk("frz_vector", 32'(bus.vector), 32'd28);
        chk("frz_pending", 32'(bus.pending), 32'h5);
        chk("frz_irq_out", 32'(bus.irq_out), 32'd1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("frz_active", 32'(bus.active), 32'h4);
        chk("frz_pending_left", 32'(bus.pending), 32'h1);
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        step();
        chk("frz_next_irq", 32'(bus.irq_out), 32'd1);
        chk("frz_next_vector", 32'(bus.vector), 32'd24);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        // new edge on the selected line in the ack cycle: set wins
        bus.irq_in = 4'b0010;
        step();
        bus.irq_in = 4'b0000;
        step();
        chk("setwin_vector", 32'(bus.vector), 32'd26);
        bus.irq_in = 4'b0010; bus.irq_ack = 1'b1;
        step();
        bus.irq_in = 4'b0000; bus.irq_ack = 1'b0;
        chk("setwin_pending", 32'(bus.pending), 32'h2);
        chk("setwin_active", 32'(bus.active), 32'h2);
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        step();
        chk("setwin_reserve", 32'(bus.irq_out), 32'd1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        chk("setwin_drained", 32'(bus.pending), 32'h0);
        // level held high yields exactly one service
        bus.irq_in = 4'b0010;
        step();
        step();
        chk("level_req", 32'(bus.irq_out), 32'd1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("level_busy", 32'(bus.busy), 32'd0);
        chk("level_pending", 32'(bus.pending), 32'h0);
        bus.irq_in = 4'b0000;
        bus.iret = 1'b1; bus.irq_ack = 1'b1;
        step();
        bus.iret = 1'b0; bus.irq_ack = 1'b0;
        chk("strobe_busy", 32'(bus.busy), 32'd0);
        chk("strobe_irq", 32'(bus.irq_out), 32'd0);
        chk("strobe_active", 32'(bus.active), 32'h0);
        // asynchronous reset during SERVICE
        bus.irq_in = 4'b0010;
        step();
        step();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("rst_pre_active", 32'(bus.active), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        step();
        step();
        rst_n = 1'b1;
        bus.mask_we = 1'b1; bus.mask_in = 4'b1111;
        step();
        bus.mask_we = 1'b0;
        step();
        step();
        chk("rel_no_pending", 32'(bus.pending), 32'h0);
        chk("rel_no_irq", 32'(bus.irq_out), 32'd0);
        bus.irq_in = 4'b0000;
        step();
        bus.irq_in = 4'b0010;
        step();
        chk("rel_edge_pending", 32'(bus.pending), 32'h2);
        step();
        chk("rel_edge_irq", 32'(bus.irq_out), 32'd1);
        chk("rel_edge_vector", 32'(bus.vector), 32'd26);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_IRQ, 4, number of interrupt request lines; index 0 is the highest priority.
REQ-002 Parameter VEC_WIDTH, 5, vector width; equals the program-counter width.
REQ-003 Parameter VEC_BASE, 5'd24, ROM address of the vector table.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 IRQ_IN  in  N_IRQ  request lines, synchronous to CLK; rising-edge triggered.
REQ-008 MASK_WE  in  1  mask write strobe.
REQ-009 MASK_IN  in  N_IRQ  mask write data; 1 = enabled.
REQ-010 IRQ_ACK  in  1  core accepted: return address pushed to stack, VECTOR loaded into PC.
REQ-011 IRET  in  1  core executed return-from-interrupt.
REQ-012 IRQ_OUT  out  1  interrupt request to core.
REQ-013 VECTOR  out  VEC_WIDTH  PC load address for the current winner.
REQ-014 ACTIVE  out  N_IRQ  one-hot in-service line; all zeros when none.
REQ-015 PENDING  out  N_IRQ  latched pending bits.
REQ-016 BUSY  out  1  high in REQ or SERVICE.

Function
REQ-017 Edge detect: PENDING[i] SHALL set on the edge where IRQ_IN[i]=1 and the previous sample is 0; level-high holds generate no repeat.
REQ-018 MASK SHALL load MASK_IN on the edge where MASK_WE=1; the new value is effective from the next cycle.
REQ-019 FSM states: IDLE, REQ, SERVICE; registered; no nesting.
REQ-020 IDLE: if (PENDING & MASK) != 0, the FSM SHALL go to REQ and latch SEL = lowest set index.
REQ-021 REQ: IRQ_OUT=1; SEL and VECTOR frozen; later higher-priority arrivals and mask changes do not alter the committed SEL.
REQ-022 REQ + IRQ_ACK: the FSM SHALL go to SERVICE, clear PENDING[SEL], and set ACTIVE = onehot(SEL).
REQ-023 SERVICE: IRQ_OUT=0; on IRET the FSM SHALL go to IDLE with ACTIVE=0.
REQ-024 IRQ_ACK outside REQ and IRET outside SERVICE SHALL be ignored.
REQ-025 VECTOR = (VEC_BASE + 2*SEL) mod 2^VEC_WIDTH; two ROM words per entry; the value is held after SERVICE until the next REQ.
REQ-026 Latency: edge sampled at clock k -> PENDING at k -> IRQ_OUT high after clock k+1.
REQ-027 New edge on bit SEL in the IRQ_ACK cycle: set wins, and PENDING[SEL] stays 1.
REQ-028 Masked pending bits SHALL be retained, not dropped, and are served once unmasked.
REQ-029 Pending bits for other lines SHALL accumulate during SERVICE and be arbitrated on return to IDLE (back-to-back REQ one cycle after IRET).

Reset
REQ-030 nRST low SHALL asynchronously force: state IDLE, PENDING=0, MASK=0, previous-sample=0, SEL=0, IRQ_OUT=0, VECTOR=0, ACTIVE=0, BUSY=0.
REQ-031 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt with no residual pending bit.
REQ-032 After release, a line already high SHALL NOT trigger until it goes low then high.

Structure
REQ-033 The shared package SHALL hold the state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), N_IRQ, VEC_WIDTH and VEC_BASE.
REQ-034 Sub-module prio_enc4 SHALL be combinational: lowest-set-bit index plus valid flag.
REQ-035 State 2'd3 SHALL recover to IDLE.

Verification
REQ-036 MASK=4'b1111; pulse IRQ_IN[2] -> IRQ_OUT high 2 cycles later, VECTOR=5'd28; IRQ_ACK -> ACTIVE=4'b0100, PENDING=0; IRET -> BUSY=0.
REQ-037 IRQ_IN[1] and IRQ_IN[3] rise together -> VECTOR=5'd26 first; after IRET, next cycle REQ with VECTOR=5'd30.
REQ-038 MASK=4'b1110; pulse IRQ_IN[0] -> PENDING=4'b0001, no IRQ_OUT; write MASK=4'b1111 -> IRQ_OUT 1 cycle later, VECTOR=5'd24.
REQ-039 In REQ for line 2, pulse IRQ_IN[0] -> VECTOR stays 5'd28; line 0 is served after IRET.
REQ-040 IRQ_IN[1] held high for 20 cycles -> exactly one service; IRET/IRQ_ACK strobes while IDLE -> no state change.
REQ-041 nRST low during SERVICE -> all outputs 0 immediately; with IRQ_IN[1] high at release -> no request until a new rising edge.
